// File: rtl/siren.sv
// Keypad-controlled intrusion alarm: arm/disarm by 4-bit codes, entry delay on any sensor trip,
// siren after the delay expires. All state advances only on enabled clock edges.
module siren #(
    parameter logic [3:0]  ARM_CODE     = 4'b0011,
    parameter logic [3:0]  DISARM_CODE  = 4'b1100,
    parameter int unsigned DELAY_CYCLES = 100,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ENA,
    input  logic [3:0] keypad,
    input  logic       front_door,
    input  logic       rear_door,
    input  logic       window,
    output logic       alarm_siren,
    output logic       is_armed,
    output logic       is_wait_delay
);

    typedef enum logic [1:0] {
        StDisarmed,
        StArmed,
        StWaitDelay,
        StAlarm
    } state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trip;
    logic             disarm_hit;
    logic             arm_hit;

    assign trip       = front_door | rear_door | window;
    assign disarm_hit = (keypad == DISARM_CODE);
    assign arm_hit    = (keypad == ARM_CODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StDisarmed;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Disarm always wins over trip and over delay expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ENA) begin
            unique case (state_q)
                StDisarmed: begin
                    if (arm_hit) state_d = StArmed;
                end
                StArmed: begin
                    if (disarm_hit) begin
                        state_d = StDisarmed;
                    end else if (trip) begin
                        state_d = StWaitDelay;
                        cnt_d   = '0;
                    end
                end
                StWaitDelay: begin
                    if (disarm_hit) begin
                        state_d = StDisarmed;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StAlarm;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StAlarm: begin
                    if (disarm_hit) state_d = StDisarmed;
                end
                default: begin
                    state_d = StDisarmed;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        alarm_siren   = 1'b0;
        is_armed      = 1'b0;
        is_wait_delay = 1'b0;
        unique case (state_q)
            StDisarmed: ;
            StArmed: begin
                is_armed = 1'b1;
            end
            StWaitDelay: begin
                is_armed      = 1'b1;
                is_wait_delay = 1'b1;
            end
            StAlarm: begin
                alarm_siren = 1'b1;
                is_armed    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_siren.sv
// Scoreboard bench for siren: a behavioural model predicts {alarm_siren, is_armed, is_wait_delay}
// for every driven cycle; predictions are queued and compared after the clock edge.
module tb_siren;

    localparam logic [3:0]  Arm   = 4'b0011;
    localparam logic [3:0]  Dis   = 4'b1100;
    localparam int unsigned Delay = 100;

    logic       clk;
    logic       reset;
    logic       ENA;
    logic [3:0] keypad;
    logic       front_door;
    logic       rear_door;
    logic       window;
    logic       alarm_siren;
    logic       is_armed;
    logic       is_wait_delay;

    siren dut (
        .clk          (clk),
        .reset        (reset),
        .ENA          (ENA),
        .keypad       (keypad),
        .front_door   (front_door),
        .rear_door    (rear_door),
        .window       (window),
        .alarm_siren  (alarm_siren),
        .is_armed     (is_armed),
        .is_wait_delay(is_wait_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec;
    int         n_bad;
    logic [2:0] exp_q[$];
    int         m_state;  // 0 disarmed, 1 armed, 2 entry delay, 3 alarm
    int         m_left;   // enabled edges remaining before the siren

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_out();
        case (m_state)
            1:       return 3'b010;
            2:       return 3'b011;
            3:       return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_step(input logic e, input logic [3:0] k, input logic [2:0] s);
        if (!reset) begin
            m_state = 0;
            return;
        end
        if (!e) return;
        case (m_state)
            0: if (k == Arm) m_state = 1;
            1: begin
                if (k == Dis) m_state = 0;
                else if (s != 3'b000) begin
                    m_state = 2;
                    m_left  = Delay;
                end
            end
            2: begin
                if (k == Dis) m_state = 0;
                else begin
                    m_left--;
                    if (m_left == 0) m_state = 3;
                end
            end
            default: if (k == Dis) m_state = 0;
        endcase
    endtask

    task automatic pop_check(input string tag);
        logic [2:0] exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, {29'd0, alarm_siren, is_armed, is_wait_delay}, {29'd0, exp});
        end
    endtask

    task automatic tick(input string tag, input logic e, input logic [3:0] k, input logic [2:0] s);
        ENA    = e;
        keypad = k;
        {front_door, rear_door, window} = s;
        model_step(e, k, s);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    // Asserts reset between edges and expects outputs to clear without a clock.
    task automatic reset_mid(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_state = 0;
        exp_q.push_back(model_out());
        pop_check({tag, "_async"});
        for (int i = 0; i < 3; i++) tick({tag, "_held"}, 1'b1, Arm, 3'b111);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int wcnt;
        int guard;
        n_vec   = 0;
        n_bad   = 0;
        m_state = 0;
        m_left  = 0;
        reset   = 1'b0;
        ENA     = 1'b1;
        keypad  = 4'd0;
        {front_door, rear_door, window} = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {29'd0, alarm_siren, is_armed, is_wait_delay}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Code sweeps in DISARMED and ARMED.
        for (int c = 0; c < 16; c++)
            if (c != 3) repeat (2) tick("sweep_disarmed", 1'b1, 4'(c), 3'b000);
        tick("arm", 1'b1, Arm, 3'b000);
        for (int c = 0; c < 16; c++)
            if (c != 3 && c != 12) tick("sweep_armed", 1'b1, 4'(c), 3'b000);
        tick("disarm", 1'b1, Dis, 3'b000);

        // Trip then disarm inside the entry delay.
        tick("arm2", 1'b1, Arm, 3'b000);
        repeat (4) tick("armed_idle", 1'b1, 4'd0, 3'b000);
        tick("window_trip", 1'b1, 4'd0, 3'b001);
        repeat (2) tick("wait_sensor_clear", 1'b1, 4'd0, 3'b000);
        tick("disarm_in_wait", 1'b1, Dis, 3'b000);

        // Full entry delay into ALARM.
        tick("arm3", 1'b1, Arm, 3'b000);
        wcnt = 0;
        for (int i = 0; i < 128; i++) begin
            tick("rear_hold", 1'b1, 4'd0, 3'b010);
            if (is_wait_delay) wcnt++;
        end
        chk("wait_len", wcnt, Delay);
        for (int c = 0; c < 16; c++)
            if (c != 12) tick("sweep_alarm", 1'b1, 4'(c), 3'($urandom_range(0, 7)));
        tick("disarm_alarm", 1'b1, Dis, 3'b000);
        tick("rearm_level", 1'b1, Arm, 3'b000);
        tick("disarm_again", 1'b1, Dis, 3'b000);

        // Asynchronous reset from ARMED, WAIT_DELAY and ALARM.
        tick("arm4", 1'b1, Arm, 3'b000);
        reset_mid("rst_armed");
        tick("arm5", 1'b1, Arm, 3'b000);
        tick("trip5", 1'b1, 4'd0, 3'b100);
        repeat (10) tick("wait5", 1'b1, 4'd0, 3'b000);
        reset_mid("rst_wait");
        tick("arm6", 1'b1, Arm, 3'b000);
        repeat (Delay + 5) tick("to_alarm6", 1'b1, 4'd0, 3'b001);
        reset_mid("rst_alarm");

        // Every sensor combination triggers the entry delay.
        for (int s = 1; s < 8; s++) begin
            tick("combo_arm", 1'b1, Arm, 3'b000);
            repeat (2) tick("combo_trip", 1'b1, 4'd0, 3'(s));
            tick("combo_disarm", 1'b1, Dis, 3'b000);
        end

        // Clock-enable gating.
        tick("ena_off_arm", 1'b0, Arm, 3'b000);
        tick("ena_on_arm", 1'b1, Arm, 3'b000);
        tick("ena_off_trip", 1'b0, 4'd0, 3'b010);
        tick("ena_on_trip", 1'b1, 4'd0, 3'b010);
        guard = 0;
        while (m_state != 3 && guard < 400) begin
            tick("ena_gaps", 1'($urandom_range(0, 1)), 4'd0, 3'b000);
            guard++;
        end
        chk("ena_reached_alarm", m_state, 3);
        repeat (3) tick("ena_off_disarm", 1'b0, Dis, 3'b000);
        tick("ena_on_disarm", 1'b1, Dis, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
